// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Stall, flush and forwarding control for the five-stage core.
//                Detects load-use and CSR read-after-write hazards, freezes
//                the pipeline on data-memory wait, flushes on redirect, and
//                counts cycles spent with decode stalled (saturating).
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       r1AddrD,
    input  logic [4:0]       r2AddrD,
    input  logic             useR1D,
    input  logic             useR2D,
    input  logic             csrOpD,
    input  logic [4:0]       r1AddrE,
    input  logic [4:0]       r2AddrE,
    input  logic [4:0]       rdAddrE,
    input  logic [4:0]       rdAddrM,
    input  logic [4:0]       rdAddrW,
    input  logic             regWriteE,
    input  logic             regWriteM,
    input  logic             regWriteW,
    input  logic             loadE,
    input  logic             wrongBranch,
    input  logic             dmemWait,
    input  logic             clrCount,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic [CNT_W-1:0] stallCount
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // CSR-writing instruction present in E (bit 0), M (bit 1), W (bit 2)
    logic [2:0]       r_pend;
    logic [CNT_W-1:0] r_stall_count;

    logic w_src1_hit;
    logic w_src2_hit;
    logic w_load_use;
    logic w_csr_haz;

    // A load in E cannot feed D's operands until it reaches W
    assign w_src1_hit = useR1D & (r1AddrD == rdAddrE);
    assign w_src2_hit = useR2D & (r2AddrD == rdAddrE);
    assign w_load_use = loadE & regWriteE & (rdAddrE != 5'd0) & (w_src1_hit | w_src2_hit);
    assign w_csr_haz  = csrOpD & (|r_pend);

    // Forward select for one execute operand; M holds the newer value than W
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == src)) begin
            fwd_sel = 2'b10;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == src)) begin
            fwd_sel = 2'b01;
        end else begin
            fwd_sel = 2'b00;
        end
    endfunction

    assign fwdA = fwd_sel(r1AddrE, regWriteM, rdAddrM, regWriteW, rdAddrW);
    assign fwdB = fwd_sel(r2AddrE, regWriteM, rdAddrM, regWriteW, rdAddrW);

    // Prioritised stall/flush decode: reset > freeze > redirect > hazard
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (rst) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (dmemWait) begin
            // Whole pipe holds; a pending redirect stays in E until release
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (wrongBranch) begin
            // D is discarded, so any hazard it carries is irrelevant
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (w_load_use || w_csr_haz) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    // Track CSR writers down the pipe; a stalled/flushed D op enters E as a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 3'b000;
        end else if (!dmemWait) begin
            r_pend <= {r_pend[1:0], csrOpD & ~flushE};
        end
    end

    // Saturating count of decode-stall cycles; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (clrCount) begin
            r_stall_count <= '0;
        end else if (stallD && (r_stall_count != c_cnt_max)) begin
            r_stall_count <= r_stall_count + c_cnt_one;
        end
    end

    assign stallCount = r_stall_count;

endmodule
`default_nettype wire
